// File: rtl/basic_gate_pkg.sv
// Shared definitions for the basic gate tester: FSM encoding, fail_mask bit
// positions, vector count and small helpers used by the tester datapath.
package basic_gate_pkg;

  // Tester FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit positions of each gate inside fail_mask and the packed gate vectors
  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;
  localparam int NUM_GATES = 7;

  // Exhaustive two-input stimulus: 00, 01, 10, 11
  localparam int NUM_VECTORS = 4;
  localparam int VEC_W       = 2;

  // Settle counter and error counter widths
  localparam int SETTLE_W = 4;
  localparam int ERR_W    = 3;

  typedef logic [NUM_GATES-1:0] gate_vec_t;

  // Saturating error counter step: counts failing vectors, never past NUM_VECTORS
  function automatic logic [ERR_W-1:0] err_next(input logic [ERR_W-1:0] count,
                                                input logic             hit);
    logic [ERR_W-1:0] result;
    result = count;
    if (hit && (count < ERR_W'(NUM_VECTORS))) begin
      result = count + ERR_W'(1);
    end
    return result;
  endfunction

  // Stimulus bits for a vector index, in1 is the MSB
  function automatic logic [VEC_W-1:0] vector_bits(input logic [VEC_W-1:0] idx);
    return idx;
  endfunction

endpackage

// File: rtl/basic_gate.sv
// Golden two-input gate block. The tester uses one instance of it as the
// reference model for the gate under test.
module basic_gate (
  input  logic in1,
  input  logic in2,
  output logic out_and,
  output logic out_or,
  output logic out_not,
  output logic out_nand,
  output logic out_nor,
  output logic out_xor,
  output logic out_xnor
);

  // Pure combinational reference functions; NOT only looks at in1
  always_comb begin
    out_and  = in1 & in2;
    out_or   = in1 | in2;
    out_not  = ~in1;
    out_nand = ~(in1 & in2);
    out_nor  = ~(in1 | in2);
    out_xor  = in1 ^ in2;
    out_xnor = ~(in1 ^ in2);
  end

endmodule

// File: rtl/basic_gate_tester.sv
// Exhaustive tester for a two-input basic gate block. Walks the four input
// vectors, lets each settle for SETTLE_CYCLES cycles, then compares the seven
// observed outputs against a golden basic_gate fed from the same stimulus.
// SETTLE_CYCLES must lie in 1..15 so it fits the 4-bit settle counter.
module basic_gate_tester
  import basic_gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 drv_in1,
  output logic                 drv_in2,
  input  logic                 obs_and,
  input  logic                 obs_or,
  input  logic                 obs_not,
  input  logic                 obs_nand,
  input  logic                 obs_nor,
  input  logic                 obs_xor,
  input  logic                 obs_xnor,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask,
  output logic [ERR_W-1:0]     err_count
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0]    LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

  state_t               state;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [VEC_W-1:0]     vec_idx;
  logic [VEC_W-1:0]     next_vec;

  logic                 gold_and;
  logic                 gold_or;
  logic                 gold_not;
  logic                 gold_nand;
  logic                 gold_nor;
  logic                 gold_xor;
  logic                 gold_xnor;

  gate_vec_t            expected;
  gate_vec_t            observed;
  gate_vec_t            mismatch;
  gate_vec_t            mask_after_check;
  logic                 any_mismatch;

  // Reference outputs come from the registered stimulus, so they are stable
  // for the whole settle window just like the gate under test
  basic_gate u_golden (
    .in1      (drv_in1),
    .in2      (drv_in2),
    .out_and  (gold_and),
    .out_or   (gold_or),
    .out_not  (gold_not),
    .out_nand (gold_nand),
    .out_nor  (gold_nor),
    .out_xor  (gold_xor),
    .out_xnor (gold_xnor)
  );

  // Pack reference and observed outputs into fail_mask bit order and compare
  always_comb begin
    expected            = '0;
    observed            = '0;
    expected[GATE_AND]  = gold_and;
    expected[GATE_OR]   = gold_or;
    expected[GATE_NOT]  = gold_not;
    expected[GATE_NAND] = gold_nand;
    expected[GATE_NOR]  = gold_nor;
    expected[GATE_XOR]  = gold_xor;
    expected[GATE_XNOR] = gold_xnor;
    observed[GATE_AND]  = obs_and;
    observed[GATE_OR]   = obs_or;
    observed[GATE_NOT]  = obs_not;
    observed[GATE_NAND] = obs_nand;
    observed[GATE_NOR]  = obs_nor;
    observed[GATE_XOR]  = obs_xor;
    observed[GATE_XNOR] = obs_xnor;
    mismatch            = expected ^ observed;
    any_mismatch        = |mismatch;
    mask_after_check    = fail_mask | mismatch;
    next_vec            = vec_idx + VEC_W'(1);
  end

  // Run sequencer: all outputs are registered here so they are glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      vec_idx    <= '0;
      drv_in1    <= 1'b0;
      drv_in2    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= '0;
      err_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state              <= ST_SETTLE;
            settle_cnt         <= '0;
            vec_idx            <= '0;
            {drv_in1, drv_in2} <= vector_bits('0);
            busy               <= 1'b1;
            pass               <= 1'b0;
            fail_mask          <= '0;
            err_count          <= '0;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end

        ST_CHECK: begin
          fail_mask <= mask_after_check;
          err_count <= err_next(err_count, any_mismatch);
          if (vec_idx == LAST_VEC) begin
            // Pass is judged on the mask including this last vector
            state              <= ST_DONE;
            busy               <= 1'b0;
            done               <= 1'b1;
            pass               <= (mask_after_check == '0);
            {drv_in1, drv_in2} <= 2'b00;
          end else begin
            state              <= ST_SETTLE;
            vec_idx            <= next_vec;
            {drv_in1, drv_in2} <= vector_bits(next_vec);
          end
        end

        ST_DONE: begin
          // start is deliberately not sampled here; one IDLE cycle follows
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/basic_gate_tester.md
BASIC_GATE_TESTER -- requirements
Module: basic_gate_tester

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: SETTLE_CYCLES, default 2, number of cycles each stimulus vector is held before its outputs are compared; legal range 1..15.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  run request, sampled only in IDLE.
REQ-006 Port: drv_in1, drv_in2  output  1 each  stimulus to the gate under test.
REQ-007 Port: obs_and, obs_or, obs_not, obs_nand, obs_nor, obs_xor, obs_xnor  input  1 each  observed gate outputs.
REQ-008 Port: busy  output  1  high while a run is in progress.
REQ-009 Port: done  output  1  one-cycle pulse at the end of a run.
REQ-010 Port: pass  output  1  high when the last completed run had no mismatch.
REQ-011 Port: fail_mask  output  7  sticky per-gate mismatch flags: [0]and [1]or [2]not [3]nand [4]nor [5]xor [6]xnor.
REQ-012 Port: err_count  output  3  number of vectors (0..4) with at least one mismatch.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, CHECK and DONE.
REQ-014 In IDLE with start=1 at a rising edge, the FSM SHALL go to SETTLE with vector 0, clear fail_mask and err_count, and drop pass.
REQ-015 Vectors SHALL be applied in the order {drv_in1,drv_in2} = 00, 01, 10, 11.
REQ-016 The FSM SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles and then go to CHECK.
REQ-017 In CHECK (one cycle), the seven obs_* inputs SHALL be compared against expected values computed from the current drv_in1/drv_in2 (and, or, ~in1, nand, nor, xor, xnor).
REQ-018 At the end of CHECK, each mismatching gate SHALL set its fail_mask bit, and err_count SHALL increment by 1 if any bit mismatched; err_count saturates at 4.
REQ-019 After CHECK of vectors 0..2, the FSM SHALL go to SETTLE with the next vector; after CHECK of vector 3 it SHALL go to DONE.
REQ-020 DONE SHALL last one cycle with done=1 and pass=(fail_mask==0); the FSM then returns to IDLE.
REQ-021 pass, fail_mask and err_count SHALL hold until the next accepted start or reset.
REQ-022 busy SHALL be 1 in SETTLE and CHECK, and 0 in IDLE and DONE.
REQ-023 start SHALL be ignored outside IDLE, including during DONE.
REQ-024 A start held high continuously SHALL produce back-to-back runs with exactly one IDLE cycle between them.
REQ-025 Latency: done SHALL be high in the cycle following 4*(SETTLE_CYCLES+1) rising edges after the edge that accepted start (12 for the default).
REQ-026 drv_in1/drv_in2 SHALL be registered outputs that change only at vector transitions and are 00 in IDLE and DONE.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, drv_in1=drv_in2=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, and settle counter=0.
REQ-028 Reset mid-run SHALL abandon the run with no done pulse; the first start after reset release SHALL begin a fresh run from vector 0.

Structure
REQ-029 A shared package basic_gate_pkg SHALL hold the FSM state encoding, the gate index constants for fail_mask bit positions, and NUM_VECTORS=4.
REQ-030 The expected values SHALL come from one sub-module: a golden instance of the team's basic_gate driven by drv_in1/drv_in2.
REQ-031 The settle counter SHALL be 4 bits wide.

Verification
REQ-032 Correct basic_gate connected, default parameter, one start pulse -> done at cycle 12, pass=1, fail_mask=0x00, err_count=0.
REQ-033 obs_xor stuck at 0 -> mismatches at vectors 01 and 10 -> fail_mask=0x20, err_count=2, pass=0.
REQ-034 obs_not wired to in1 instead of ~in1 -> all 4 vectors fail -> fail_mask=0x04, err_count=4.
REQ-035 rst pulsed during SETTLE of vector 2 -> all outputs 0 at once, no done; a new start then gives a clean run with pass=1.
REQ-036 start pulsed while busy, then start held high for 30 cycles -> the extra pulse is ignored; runs complete back-to-back with one IDLE cycle between done pulses.
REQ-037 SETTLE_CYCLES=1 with a correct DUT -> done at cycle 8, pass=1.
